// File: rtl/ab_dispatch_if.sv
// rtl/ab_dispatch_if.sv - signal bundle between ab_dispatch, its upstream feeder, the core and the result consumer
//
// Signals (directions as seen by ab_dispatch through the slave modport):
//   in_valid_i / in_ready_o / in_a_i / in_b_i   operand pair stream in
//   core_start_o / core_a_o / core_b_o          start pulse and held operands to the core
//   core_busy_i / core_y_i                      core busy flag and result
//   out_valid_o / out_ready_i / out_y_o         single-entry result stream out
interface ab_dispatch_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  in_a_i;
    logic [7:0]  in_b_i;
    logic        core_start_o;
    logic [7:0]  core_a_o;
    logic [7:0]  core_b_o;
    logic        core_busy_i;
    logic [15:0] core_y_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_y_o;

    modport slave (
        input  in_valid_i, in_a_i, in_b_i, core_busy_i, core_y_i, out_ready_i,
        output in_ready_o, core_start_o, core_a_o, core_b_o, out_valid_o, out_y_o
    );

    modport master (
        output in_valid_i, in_a_i, in_b_i, core_busy_i, core_y_i, out_ready_i,
        input  in_ready_o, core_start_o, core_a_o, core_b_o, out_valid_o, out_y_o
    );
endinterface

// File: rtl/ab_dispatch.sv
// rtl/ab_dispatch.sv - operand FIFO, one-at-a-time issue and in-order result slot for the a*cbrt(b) core
//
// Ports:
//   clk_i          clock, all logic on posedge
//   rst_i          synchronous active-high reset, shared with the core
//   bus (slave)    operand stream in, core start/operands/busy/result, result stream out
//   fifo_count_o   operand FIFO occupancy
//   done_cnt_o     results captured since reset, wraps to 0
module ab_dispatch #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ab_dispatch_if.slave           bus,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic [CNT_W-1:0]       done_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       fifo_a_q [DEPTH];
    logic [7:0]       fifo_b_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             start_q, start_d;
    logic [7:0]       core_a_q, core_a_d;
    logic [7:0]       core_b_q, core_b_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_y_q, out_y_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic             in_ready;
    logic             push;
    logic             pop;

    assign in_ready = (count_q != CNT_FULL);
    assign push     = bus.in_valid_i && in_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        core_a_d    = core_a_q;
        core_b_d    = core_b_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        done_d      = done_q;
        pop         = 1'b0;

        if (out_valid_q && bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Registered slot flag: a retire this cycle only frees issue next cycle,
                // which also guarantees capture and retire never land together.
                if ((count_q != '0) && !out_valid_q) begin
                    pop      = 1'b1;
                    core_a_d = fifo_a_q[rd_ptr_q];
                    core_b_d = fifo_b_q[rd_ptr_q];
                    start_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Busy rises a cycle after the core samples start; waiting for it
                // keeps the still-low busy from being mistaken for completion.
                if (bus.core_busy_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.core_busy_i) begin
                    out_y_d     = bus.core_y_i;
                    out_valid_d = 1'b1;
                    done_d      = done_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            start_q     <= 1'b0;
            core_a_q    <= '0;
            core_b_q    <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            start_q     <= start_d;
            core_a_q    <= core_a_d;
            core_b_q    <= core_b_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            done_q      <= done_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= bus.in_a_i;
            fifo_b_q[wr_ptr_q] <= bus.in_b_i;
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.core_start_o = start_q;
    assign bus.core_a_o     = core_a_q;
    assign bus.core_b_o     = core_b_q;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_y_o      = out_y_q;
    assign fifo_count_o     = count_q;
    assign done_cnt_o       = done_q;
endmodule

// File: tb/tb_ab_dispatch.sv
// tb/tb_ab_dispatch.sv - self-checking bench for ab_dispatch with a behavioural core and scoreboard
module tb_ab_dispatch;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic [$clog2(DEPTH):0] fifo_count_o;
    logic [CNT_W-1:0]       done_cnt_o;

    ab_dispatch_if bus ();

    ab_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .fifo_count_o (fifo_count_o),
        .done_cnt_o   (done_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_y(input logic [7:0] a, input logic [7:0] b);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(b)) r++;
        return 16'(int'(a) * r);
    endfunction

    // Behavioural core: busy rises the edge start is seen, operands read at the end.
    logic        core_busy;
    logic [15:0] core_y;
    int          core_lat;
    assign bus.core_busy_i = core_busy;
    assign bus.core_y_i    = core_y;

    always @(posedge clk_i) begin
        if (rst_i) begin
            core_busy <= 1'b0;
            core_y    <= '0;
            core_lat  <= 0;
        end else if (core_busy) begin
            if (core_lat == 0) begin
                core_busy <= 1'b0;
                core_y    <= ref_y(bus.core_a_o, bus.core_b_o);
            end else begin
                core_lat <= core_lat - 1;
            end
        end else if (bus.core_start_o) begin
            core_busy <= 1'b1;
            core_lat  <= int'($urandom_range(4, 1));
        end
    end

    // Scoreboard: queue of accepted pairs, queue of results owed, one result slot.
    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    logic [15:0] r_q[$];
    logic [15:0] ret_y[$];
    int          done_log[$];
    bit          p_rst = 1'b1, p_push = 1'b0, p_retire = 1'b0, p_capture = 1'b0, p_issue = 1'b0;
    logic [7:0]  p_a = '0, p_b = '0, cur_a = '0, cur_b = '0;
    bit          m_slot = 1'b0, m_inflight = 1'b0, m_busy_prev = 1'b0;
    logic [15:0] slot_y = '0;
    int          m_done = 0;

    always @(negedge clk_i) begin
        if (p_rst) begin
            q_a.delete(); q_b.delete(); r_q.delete();
            m_slot = 1'b0; m_inflight = 1'b0; m_done = 0;
            cur_a = '0; cur_b = '0; slot_y = '0;
            chk("rst_start", bus.core_start_o, 0);
            chk("rst_core_a", bus.core_a_o, 0);
            chk("rst_core_b", bus.core_b_o, 0);
            chk("rst_out_valid", bus.out_valid_o, 0);
            chk("rst_out_y", bus.out_y_o, 0);
            chk("rst_done", done_cnt_o, 0);
            chk("rst_count", fifo_count_o, 0);
        end else begin
            chk("start", bus.core_start_o, p_issue);
            if (p_issue) begin
                chk("issue_a", bus.core_a_o, q_a[0]);
                chk("issue_b", bus.core_b_o, q_b[0]);
                cur_a = q_a.pop_front();
                cur_b = q_b.pop_front();
                r_q.push_back(ref_y(cur_a, cur_b));
                m_inflight = 1'b1;
            end else begin
                chk("hold_a", bus.core_a_o, cur_a);
                chk("hold_b", bus.core_b_o, cur_b);
            end
            if (p_push) begin
                q_a.push_back(p_a);
                q_b.push_back(p_b);
            end
            chk("count", fifo_count_o, q_a.size());
            if (p_retire) m_slot = 1'b0;
            if (p_capture) begin
                m_slot     = 1'b1;
                slot_y     = r_q.pop_front();
                m_inflight = 1'b0;
                m_done     = (m_done + 1) % (1 << CNT_W);
                done_log.push_back(int'(done_cnt_o));
            end
            chk("out_valid", bus.out_valid_o, m_slot);
            if (m_slot) chk("out_y", bus.out_y_o, slot_y);
            chk("done_cnt", done_cnt_o, m_done);
        end
        chk("in_ready", bus.in_ready_o, q_a.size() != DEPTH);

        p_rst     = rst_i;
        p_push    = bus.in_valid_i && (q_a.size() != DEPTH);
        p_a       = bus.in_a_i;
        p_b       = bus.in_b_i;
        p_retire  = m_slot && bus.out_ready_i;
        if (p_retire && !rst_i) ret_y.push_back(bus.out_y_o);
        p_capture = m_inflight && m_busy_prev && !core_busy;
        p_issue   = !m_inflight && (q_a.size() != 0) && !m_slot;
        m_busy_prev = core_busy;
    end

    int tab[8];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        bit acc;
        int guard;
        guard = 0;
        bus.in_valid_i = 1'b1;
        bus.in_a_i = a;
        bus.in_b_i = b;
        do begin
            @(negedge clk_i);
            acc = bus.in_ready_o;
            step();
            guard++;
        end while (!acc && guard < 500);
        chk("push_timeout", acc, 1);
    endtask

    task automatic wait_retired(input int target);
        int guard;
        guard = 0;
        while (ret_y.size() < target && guard < 2000) begin
            step();
            guard++;
        end
        chk("drain_timeout", ret_y.size() >= target, 1);
    endtask

    task automatic wait_out_valid();
        int guard;
        guard = 0;
        @(negedge clk_i);
        while (!bus.out_valid_o && guard < 500) begin
            @(negedge clk_i);
            guard++;
        end
        chk("valid_timeout", bus.out_valid_o, 1);
        step();
    endtask

    task automatic check_results(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, (base + i < ret_y.size()) ? 32'(ret_y[base + i]) : 32'hFFFF_FFFF, 32'(tab[i]));
        end
    endtask

    initial begin
        int base;
        int guard;
        bus.in_valid_i  = 1'b0;
        bus.in_a_i      = '0;
        bus.in_b_i      = '0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step();

        base = ret_y.size();
        push(8'd10, 8'd27);
        bus.in_valid_i = 1'b0;
        wait_retired(base + 1);
        tab = '{30, 0, 0, 0, 0, 0, 0, 0};
        check_results("single_y", base, 1);

        base = ret_y.size();
        push(8'd255, 8'd255); push(8'd0, 8'd200); push(8'd7, 8'd0); push(8'd1, 8'd1);
        bus.in_valid_i = 1'b0;
        wait_retired(base + 4);
        tab = '{1530, 0, 0, 1, 0, 0, 0, 0};
        check_results("boundary_y", base, 4);

        chk("wrap_len", done_log.size(), 5);
        tab = '{1, 2, 3, 0, 1, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            chk("wrap_seq", (i < done_log.size()) ? 32'(done_log[i]) : 32'hFFFF_FFFF, 32'(tab[i]));
        end

        bus.out_ready_i = 1'b0;
        base = ret_y.size();
        push(8'd2, 8'd8); push(8'd3, 8'd64); push(8'd4, 8'd125); push(8'd5, 8'd216); push(8'd6, 8'd1);
        bus.in_valid_i = 1'b0;
        wait_out_valid();
        repeat (5) step();
        chk("bp_y", bus.out_y_o, 4);
        chk("bp_count", fifo_count_o, 4);
        chk("bp_ready", bus.in_ready_o, 0);
        chk("bp_start", bus.core_start_o, 0);
        bus.in_valid_i = 1'b1; bus.in_a_i = 8'd99; bus.in_b_i = 8'd99;
        repeat (3) step();
        bus.in_valid_i = 1'b0;
        chk("bp_full_count", fifo_count_o, 4);
        bus.out_ready_i = 1'b1;
        wait_retired(base + 5);
        tab = '{4, 12, 20, 30, 6, 0, 0, 0};
        check_results("bp_order", base, 5);

        bus.out_ready_i = 1'b0;
        base = ret_y.size();
        push(8'd1, 8'd8); push(8'd2, 8'd27); push(8'd3, 8'd125);
        bus.in_valid_i = 1'b0;
        wait_out_valid();
        chk("sim_pre_count", fifo_count_o, 2);
        bus.out_ready_i = 1'b1;
        step();
        bus.in_valid_i = 1'b1; bus.in_a_i = 8'd4; bus.in_b_i = 8'd64;
        step();
        bus.in_valid_i = 1'b0;
        chk("sim_count", fifo_count_o, 2);
        wait_retired(base + 4);
        tab = '{2, 6, 15, 16, 0, 0, 0, 0};
        check_results("sim_order", base, 4);

        push(8'd11, 8'd8); push(8'd12, 8'd8); push(8'd13, 8'd8); push(8'd14, 8'd8);
        bus.in_valid_i = 1'b0;
        guard = 0;
        @(negedge clk_i);
        while (!core_busy && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        chk("rst_busy_timeout", core_busy, 1);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midrst_count", fifo_count_o, 0);
        chk("midrst_valid", bus.out_valid_o, 0);
        chk("midrst_start", bus.core_start_o, 0);
        chk("midrst_core_a", bus.core_a_o, 0);
        chk("midrst_done", done_cnt_o, 0);
        chk("midrst_ready", bus.in_ready_o, 1);
        base = ret_y.size();
        push(8'd9, 8'd64);
        bus.in_valid_i = 1'b0;
        wait_retired(base + 1);
        tab = '{36, 0, 0, 0, 0, 0, 0, 0};
        check_results("post_rst_y", base, 1);

        for (int i = 0; i < 1500; i++) begin
            bus.in_valid_i  = ($urandom_range(3, 0) != 0);
            bus.in_a_i      = 8'($urandom);
            bus.in_b_i      = 8'($urandom);
            bus.out_ready_i = ($urandom_range(3, 0) != 0);
            step();
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (100) step();
        chk("final_count", fifo_count_o, 0);
        chk("final_valid", bus.out_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
